// File: rtl/rp_hdc_pkg.sv
// Shared constants and types for the sparse-HDC similarity stage.
// The stage sweeps a 4096-dim hypervector in 1024-dim chunks. It keeps one
// running score per class and then picks the best class with a sequential scan.
package rp_hdc_pkg;
  localparam int HV_DIM          = 4096;
  localparam int DIMS_PER_CC     = 1024;
  localparam int SEQ_CYCLE_COUNT = HV_DIM / DIMS_PER_CC;
  localparam int NUM_CLASSES     = 26;
  localparam int SCORE_W         = $clog2(HV_DIM + 1);
  localparam int PC_W            = $clog2(DIMS_PER_CC + 1);
  localparam int CTR_W           = $clog2(SEQ_CYCLE_COUNT);
  localparam int CLASS_W         = $clog2(NUM_CLASSES);

  typedef logic [NUM_CLASSES-1:0] class_word_t;
  typedef logic [SCORE_W-1:0]     score_t;
  typedef logic [PC_W-1:0]        pc_t;
  typedef logic [CTR_W-1:0]       ctr_t;
  typedef logic [CLASS_W-1:0]     class_idx_t;

  typedef enum logic [1:0] {IDLE, RUN, ARGMAX} sim_state_t;
endpackage

// File: rtl/rp_class_sim_acc_if.sv
// Bus between the similarity stage and its environment (chunk mux + consumer).
// Handshake: start is a request level sampled only while the stage is idle.
// There is no ready signal. busy=1 means start is ignored, and nothing is queued.
// done is a one-cycle pulse. pred_class/pred_score are valid in that cycle and
// hold until the next pulse.
// ctr selects which chunk the mux must present on query_chunk/class_chunk.
// dbg_state exposes the controller state for observation.
interface rp_class_sim_acc_if;
  import rp_hdc_pkg::*;

  logic                   start;
  logic [DIMS_PER_CC-1:0] query_chunk;
  class_word_t            class_chunk [DIMS_PER_CC];
  ctr_t                   ctr;
  logic                   busy;
  logic                   done;
  class_idx_t             pred_class;
  score_t                 pred_score;
  sim_state_t             dbg_state;

  modport master (
    output start, query_chunk, class_chunk,
    input  ctr, busy, done, pred_class, pred_score, dbg_state
  );

  modport slave (
    input  start, query_chunk, class_chunk,
    output ctr, busy, done, pred_class, pred_score, dbg_state
  );
endinterface

// File: rtl/rp_class_popcount.sv
// Per-class match count for one chunk.
// Ports:
//   i_query_chunk  query bits of the current chunk
//   i_class_chunk  per-dim class words of the current chunk
//   o_pc           per-class count of dims where query and class bit are both 1
// Purely combinational. Synthesis builds the adder tree from the summation loop.
module rp_class_popcount
  import rp_hdc_pkg::*;
(
  input  logic [DIMS_PER_CC-1:0] i_query_chunk,
  input  class_word_t            i_class_chunk [DIMS_PER_CC],
  output pc_t                    o_pc [NUM_CLASSES]
);

  pc_t w_sum;

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      w_sum = '0;
      for (int d = 0; d < DIMS_PER_CC; d++) begin
        w_sum = w_sum + pc_t'(i_query_chunk[d] & i_class_chunk[d][c]);
      end
      o_pc[c] = w_sum;
    end
  end

endmodule

// File: rtl/rp_class_sim_acc.sv
// Sequential similarity stage: accumulates per-class match counts over the four
// chunks of a query. It then scans the 26 scores one per cycle and reports the
// best class.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of rp_class_sim_acc_if (start/chunk inputs, ctr/busy/done/
//        prediction outputs, debug state)
// Timeline from the accepting edge E0: E1..E4 accumulate; E5..E30 scan classes
// 0..25; done is high in the cycle after E30.
module rp_class_sim_acc
  import rp_hdc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  rp_class_sim_acc_if.slave   bus
);

  localparam ctr_t       CTR_LAST = ctr_t'(SEQ_CYCLE_COUNT - 1);
  localparam class_idx_t IDX_LAST = class_idx_t'(NUM_CLASSES - 1);

  sim_state_t r_state;
  sim_state_t w_state_next;
  ctr_t       r_ctr;
  score_t     r_acc [NUM_CLASSES];
  class_idx_t r_idx;
  score_t     r_best_score;
  class_idx_t r_best_idx;
  class_idx_t r_pred_class;
  score_t     r_pred_score;
  logic       r_done;

  pc_t        w_pc [NUM_CLASSES];
  logic       w_last;
  logic       w_take;
  score_t     w_best_score;
  class_idx_t w_best_idx;

  rp_class_popcount u_popcount (
    .i_query_chunk (bus.query_chunk),
    .i_class_chunk (bus.class_chunk),
    .o_pc          (w_pc)
  );

  // Strict compare keeps the earliest (lowest) index on ties.
  // Because best starts at 0, all-zero scores leave class 0 as the answer.
  always_comb begin
    w_last       = (r_idx == IDX_LAST);
    w_take       = (r_acc[r_idx] > r_best_score);
    w_best_score = w_take ? r_acc[r_idx] : r_best_score;
    w_best_idx   = w_take ? r_idx : r_best_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start)         w_state_next = RUN;
      RUN:     if (r_ctr == CTR_LAST) w_state_next = ARGMAX;
      ARGMAX:  if (w_last)            w_state_next = IDLE;
      default:                        w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctr        <= '0;
      r_idx        <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_pred_class <= '0;
      r_pred_score <= '0;
      r_done       <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_ctr <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
          end
        end
        RUN: begin
          for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= r_acc[c] + score_t'(w_pc[c]);
          // ctr wraps from the last chunk back to 0 on its own.
          r_ctr <= r_ctr + ctr_t'(1);
          if (r_ctr == CTR_LAST) begin
            r_idx        <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
          end
        end
        ARGMAX: begin
          r_best_score <= w_best_score;
          r_best_idx   <= w_best_idx;
          r_idx        <= r_idx + class_idx_t'(1);
          if (w_last) begin
            r_pred_class <= w_best_idx;
            r_pred_score <= w_best_score;
            r_done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ctr        = r_ctr;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
  assign bus.pred_class = r_pred_class;
  assign bus.pred_score = r_pred_score;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_rp_class_sim_acc.sv
// Self-checking bench for rp_class_sim_acc.
// The bench stores whole hypervectors and plays the chunk mux, indexed by the
// DUT's ctr. A full-HV dot-product model predicts each query's winner. A
// timeline model gives busy/done/ctr per cycle, and one compare process
// checks every cycle. Directed tests add literal expectations.
module tb_rp_class_sim_acc;
  import rp_hdc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rp_class_sim_acc_if vif ();

  rp_class_sim_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  // Full hypervectors held by the bench.
  logic [HV_DIM-1:0] q_hv;
  class_word_t       cls_mem [HV_DIM];

  int n_checks = 0;
  int n_err    = 0;

  // Upstream mux: present chunk ctr of the stored hypervectors.
  always_comb begin
    vif.query_chunk = q_hv[int'(vif.ctr)*DIMS_PER_CC +: DIMS_PER_CC];
    for (int d = 0; d < DIMS_PER_CC; d++)
      vif.class_chunk[d] = cls_mem[int'(vif.ctr)*DIMS_PER_CC + d];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Winner over the whole HV: dot product per class, first strictly larger wins.
  function automatic logic [17:0] model_predict();
    int best_s = 0;
    int best_c = 0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      int s = 0;
      for (int d = 0; d < HV_DIM; d++)
        if (q_hv[d] && cls_mem[d][c]) s++;
      if (s > best_s) begin
        best_s = s;
        best_c = c;
      end
    end
    return {5'(best_c), 13'(best_s)};
  endfunction

  // Timeline model: m_k = edges since the accepting edge (-1 idle, 30 = done cycle).
  int          m_k = -1;
  logic [17:0] exp_q[$];
  logic [4:0]  exp_class = '0;
  logic [12:0] exp_score = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_k = -1;
      exp_q.delete();
      exp_class = '0;
      exp_score = '0;
    end else if (m_k < 0 || m_k == 30) begin
      if (vif.start) begin
        m_k = 0;
        exp_q.push_back(model_predict());
      end else begin
        m_k = -1;
      end
    end else begin
      m_k++;
      if (m_k == 30) begin
        if (exp_q.size() > 0) {exp_class, exp_score} = exp_q.pop_front();
        else chk("scoreboard_empty", 1, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_busy", int'(vif.busy), (m_k >= 0 && m_k < 30) ? 1 : 0);
      chk("cyc_done", int'(vif.done), (m_k == 30) ? 1 : 0);
      chk("cyc_ctr", int'(vif.ctr), (m_k >= 0 && m_k < 4) ? m_k : 0);
      chk("cyc_pred_class", int'(vif.pred_class), int'(exp_class));
      chk("cyc_pred_score", int'(vif.pred_score), int'(exp_score));
    end
  end

  task automatic clear_mem();
    q_hv = '1;
    for (int d = 0; d < HV_DIM; d++) cls_mem[d] = '0;
  endtask

  // One query: start for one edge, then check latency, ctr order, result and done width.
  task automatic do_query(input int ec, input int es, input string nm);
    int n;
    @(negedge clk);
    vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0;
    n = 0;
    chk({nm, "_ctr"}, int'(vif.ctr), 0);
    while (!vif.done && n < 100) begin
      @(negedge clk);
      n++;
      if (n <= 4) chk({nm, "_ctr"}, int'(vif.ctr), n % 4);
    end
    chk({nm, "_latency"}, n, 30);
    chk({nm, "_class"}, int'(vif.pred_class), ec);
    chk({nm, "_score"}, int'(vif.pred_score), es);
    @(negedge clk);
    chk({nm, "_done_width"}, int'(vif.done), 0);
    chk({nm, "_hold_score"}, int'(vif.pred_score), es);
  endtask

  task automatic setup_t1();
    clear_mem();
    for (int d = 0; d < HV_DIM; d++) cls_mem[d][7] = 1'b1;
  endtask

  initial begin
    int n;
    logic [17:0] r;
    vif.start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctr", int'(vif.ctr), 0);
    chk("rst_busy", int'(vif.busy), 0);
    chk("rst_done", int'(vif.done), 0);
    chk("rst_class", int'(vif.pred_class), 0);
    chk("rst_score", int'(vif.pred_score), 0);
    rst = 1'b0;

    // T1: class 7 set on every dim, query all ones.
    setup_t1();
    do_query(7, 4096, "t1");

    // T2: class 5 only in chunk 2 dims 0..9; class 9 lives where the query is 0.
    clear_mem();
    q_hv[1*DIMS_PER_CC +: DIMS_PER_CC] = '0;
    for (int i = 0; i < 10; i++) cls_mem[2*DIMS_PER_CC + i][5] = 1'b1;
    for (int i = 0; i < 50; i++) cls_mem[1*DIMS_PER_CC + i][9] = 1'b1;
    do_query(5, 10, "t2");

    // T3: classes 3 and 20 tie at 100 (20 straddles chunks 2/3), class 11 has 50.
    clear_mem();
    for (int i = 0; i < 100; i++) cls_mem[i][3] = 1'b1;
    for (int i = 0; i < 100; i++) cls_mem[3000 + i][20] = 1'b1;
    for (int i = 0; i < 50; i++) cls_mem[1500 + i][11] = 1'b1;
    do_query(3, 100, "t3");

    // T4: nothing matches.
    clear_mem();
    do_query(0, 0, "t4");

    // Model-only query over pseudo-random sparse vectors.
    for (int d = 0; d < HV_DIM; d++) begin
      q_hv[d] = 1'($urandom_range(0, 1));
      cls_mem[d] = class_word_t'($urandom()) & class_word_t'($urandom());
    end
    r = model_predict();
    do_query(int'(r[17:13]), int'(r[12:0]), "rand");

    // T5: start held high; the next query starts on the edge after the done cycle.
    setup_t1();
    @(negedge clk);
    vif.start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!vif.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_first_latency", n, 30);
    chk("t5_busy_in_done", int'(vif.busy), 0);
    @(negedge clk);
    chk("t5_busy_again", int'(vif.busy), 1);
    chk("t5_done_low", int'(vif.done), 0);
    n = 0;
    while (!vif.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_second_latency", n, 30);
    chk("t5_class", int'(vif.pred_class), 7);
    chk("t5_score", int'(vif.pred_score), 4096);
    vif.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_idle", int'(vif.busy), 0);

    // T6: reset in the ARGMAX cycle that examines idx 10.
    @(negedge clk);
    vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("t6_in_argmax", int'(vif.dbg_state == ARGMAX), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ctr", int'(vif.ctr), 0);
    chk("t6_rst_busy", int'(vif.busy), 0);
    chk("t6_rst_done", int'(vif.done), 0);
    chk("t6_rst_class", int'(vif.pred_class), 0);
    chk("t6_rst_score", int'(vif.pred_score), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (vif.done) n++;
    end
    chk("t6_no_done", n, 0);
    do_query(7, 4096, "t6_fresh");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
